// File: rtl/l2_mem_arbiter_pkg.sv
// Shared types for the L2 block-port arbiter: FSM states, port ids and default widths.
// No logic here; imported by the arbiter, its round-robin helper and the bus interface.
package l2_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    GUARD = 2'd3
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/l2_mem_arbiter_if.sv
// Cache-side and memory-side signal bundle of the L2 arbiter.
// slave = arbiter view, master = the surrounding caches and memory.
interface l2_mem_arbiter_if
  import l2_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l2_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational grant, last_grant updated only when upd is high.
// On a tie the port that did not win last time is granted.
module rr_arb2
  import l2_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,  // bit index is the port_t value
  input  logic       upd,
  output logic [1:0] gnt
);
  port_t last_grant;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant == PORT_I) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_I;
    end else if (upd && (gnt != 2'b00)) begin
      last_grant <= gnt[1] ? PORT_D : PORT_I;
    end
  end
endmodule

// File: rtl/l2_mem_arbiter.sv
// Shares one block memory port between ICache and DCache, one transaction at a time, round-robin.
// All outputs registered: grant->mem request +1 cycle, mem_ready->ready pulse +1, then one guard cycle.
module l2_mem_arbiter
  import l2_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
)
(
  input  logic                clk,
  input  logic                proc_reset,
  l2_mem_arbiter_if.slave     bus
);
  state_t            state_q, state_d;
  port_t             owner_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_ready_q, d_ready_q;
  logic [1:0]        req, gnt;
  logic              grant_en, done;

  assign req      = {bus.d_read | bus.d_write, bus.i_read};
  assign grant_en = (state_q == IDLE) && (req != 2'b00);
  assign done     = (state_q == BUSY) && bus.mem_ready;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (proc_reset),
    .req (req),
    .upd (grant_en),
    .gnt (gnt)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // GUARD exists so the owner's still-high request is not granted again
  // while its registered ready pulse reaches the cache.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req != 2'b00) state_d = BUSY;
      BUSY:    if (bus.mem_ready) state_d = RESP;
      RESP:    state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      owner_q     <= PORT_I;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      if (grant_en) begin
        if (gnt[1]) begin
          // A write-back wins if the DCache raises both strobes.
          owner_q     <= PORT_D;
          addr_q      <= bus.d_addr;
          wdata_q     <= bus.d_wdata;
          mem_write_q <= bus.d_write;
          mem_read_q  <= ~bus.d_write;
        end else begin
          owner_q     <= PORT_I;
          addr_q      <= bus.i_addr;
          wdata_q     <= '0;
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b1;
        end
      end
      if (done) begin
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
        if (owner_q == PORT_I) begin
          i_ready_q <= 1'b1;
          if (mem_read_q) i_rdata_q <= bus.mem_rdata;
        end else begin
          d_ready_q <= 1'b1;
          if (mem_read_q) d_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;

  a_no_read_and_write: assert property (@(posedge clk) disable iff (proc_reset)
    !(bus.d_read && bus.d_write));
endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Scoreboard bench for l2_mem_arbiter: directed stimulus queues expected memory requests and
// ready/rdata responses; independent monitor and memory-model processes consume them.
module tb_l2_mem_arbiter;
  typedef struct {
    bit          wr;
    logic [27:0] addr;
    logic [127:0] wdata;
    int          cyc;
  } mreq_t;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } rsp_t;

  typedef struct {
    int           lat;
    logic [127:0] data;
  } mrsp_t;

  logic clk = 1'b0;
  logic proc_reset;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  mreq_t exp_mem_q[$];
  rsp_t  exp_i_q[$];
  rsp_t  exp_d_q[$];
  mrsp_t mem_q[$];

  logic [127:0] sdat [8];

  localparam logic [127:0] A01  = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AA01;
  localparam logic [127:0] BSEC = 128'hBBBB_0000_0000_0000_0000_0000_0000_0002;
  localparam logic [127:0] W55  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
  localparam logic [127:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] DW1  = 128'h1357_9BDF_0000_0000_0000_0000_0000_003C;
  localparam logic [127:0] DW2  = 128'h2468_ACE0_0000_0000_0000_0000_0000_003D;
  localparam logic [127:0] RD_D = 128'hD00D_0000_0000_0000_0000_0000_0000_0278;
  localparam logic [127:0] RD_I = 128'h1CE0_0000_0000_0000_0000_0000_0000_0078;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_mem_arbiter_if bus ();

  l2_mem_arbiter dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .bus        (bus.slave)
  );

  task automatic chk_val(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic unexpected(input string nm);
    n_total++;
    $display("FAIL %s: got an event, expected none (cycle %0d)", nm, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_mreq(input bit wr, input logic [27:0] addr, input logic [127:0] wd, input int c);
    mreq_t m;
    m.wr = wr; m.addr = addr; m.wdata = wd; m.cyc = c;
    exp_mem_q.push_back(m);
  endtask

  task automatic exp_i(input logic [127:0] d, input int c);
    rsp_t r;
    r.data = d; r.cyc = c;
    exp_i_q.push_back(r);
  endtask

  task automatic exp_d(input logic [127:0] d, input int c);
    rsp_t r;
    r.data = d; r.cyc = c;
    exp_d_q.push_back(r);
  endtask

  task automatic mem_rsp(input int lat, input logic [127:0] d);
    mrsp_t r;
    r.lat = lat; r.data = d;
    mem_q.push_back(r);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_bit({tag, "_mem_read"},  bus.mem_read,  1'b0);
    chk_bit({tag, "_mem_write"}, bus.mem_write, 1'b0);
    chk_val({tag, "_mem_addr"},  128'(bus.mem_addr), 128'h0);
    chk_val({tag, "_mem_wdata"}, bus.mem_wdata, 128'h0);
    chk_bit({tag, "_i_ready"},   bus.i_ready,   1'b0);
    chk_bit({tag, "_d_ready"},   bus.d_ready,   1'b0);
    chk_val({tag, "_i_rdata"},   bus.i_rdata,   128'h0);
    chk_val({tag, "_d_rdata"},   bus.d_rdata,   128'h0);
  endtask

  // Downstream memory: answers each new request after its queued latency.
  initial begin : mem_model
    bit    active;
    int    cnt;
    mrsp_t cur;
    active = 1'b0;
    cnt = 0;
    cur.lat = 1;
    cur.data = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          if (mem_q.size() > 0) cur = mem_q.pop_front();
          else begin cur.lat = 1; cur.data = '0; end
        end
        cnt++;
        if (cnt == cur.lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = cur.data;
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  initial begin : monitor
    bit    active;
    bit    have;
    mreq_t cur;
    rsp_t  r;
    active = 1'b0;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
        if (!active) begin
          active = 1'b1;
          if (exp_mem_q.size() == 0) begin
            unexpected("mem_request");
            have = 1'b0;
          end else begin
            cur = exp_mem_q.pop_front();
            have = 1'b1;
            chk_int("mem_req_cycle", cyc, cur.cyc);
          end
        end
        if (have) begin
          chk_bit("mem_read_held",  bus.mem_read,  !cur.wr);
          chk_bit("mem_write_held", bus.mem_write, cur.wr);
          chk_val("mem_addr_held",  128'(bus.mem_addr), 128'(cur.addr));
          if (cur.wr) chk_val("mem_wdata_held", bus.mem_wdata, cur.wdata);
        end
      end else begin
        active = 1'b0;
      end
      if (bus.i_ready === 1'b1) begin
        if (exp_i_q.size() == 0) unexpected("i_ready");
        else begin
          r = exp_i_q.pop_front();
          chk_int("i_ready_cycle", cyc, r.cyc);
          chk_val("i_rdata", bus.i_rdata, r.data);
        end
      end
      if (bus.d_ready === 1'b1) begin
        if (exp_d_q.size() == 0) unexpected("d_ready");
        else begin
          r = exp_d_q.pop_front();
          chk_int("d_ready_cycle", cyc, r.cyc);
          chk_val("d_rdata", bus.d_rdata, r.data);
        end
      end
    end
  end

  initial begin : driver
    int t0;
    int t1;
    sdat[0] = 128'h0D00_0000_1111_1111_2222_2222_3333_3333;
    sdat[1] = 128'h01A1_0000_4444_4444_5555_5555_6666_6666;
    sdat[2] = 128'h0D02_0000_7777_7777_8888_8888_9999_9999;
    sdat[3] = 128'h01A3_0000_AAAA_AAAA_BBBB_BBBB_CCCC_CCCC;
    sdat[4] = 128'h0D04_0000_DDDD_DDDD_EEEE_EEEE_FFFF_FFFF;
    sdat[5] = 128'h01A5_0000_0123_4567_89AB_CDEF_0000_0005;
    sdat[6] = 128'h0D06_0000_FEDC_BA98_7654_3210_0000_0006;
    sdat[7] = 128'h01A7_0000_0F0F_0F0F_F0F0_F0F0_0000_0007;

    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    proc_reset = 1'b1;
    tick(3);
    proc_reset = 1'b0;
    tick(1);
    chk_all_zero("reset");

    // I-only read, slow memory, then a second grant while i_read stays high.
    t0 = cyc;
    bus.i_addr = 28'h0000010;
    bus.i_read = 1'b1;
    mem_rsp(3, A01);  exp_mreq(1'b0, 28'h0000010, '0, t0 + 1); exp_i(A01, t0 + 4);
    mem_rsp(1, BSEC); exp_mreq(1'b0, 28'h0000010, '0, t0 + 7); exp_i(BSEC, t0 + 8);
    tick(3);
    chk_bit("t1_mem_read_c3", bus.mem_read, 1'b1);
    tick(1);
    chk_bit("t1_mem_read_c4", bus.mem_read, 1'b0);
    chk_val("t1_i_rdata_c4", bus.i_rdata, A01);
    tick(2);
    chk_val("t1_i_rdata_c6", bus.i_rdata, A01);
    tick(1);
    bus.i_read = 1'b0;
    tick(4);
    chk_val("t1_i_rdata_final", bus.i_rdata, BSEC);

    proc_reset = 1'b1;
    tick(2);
    proc_reset = 1'b0;
    tick(1);

    // Tie after reset: D first, then strict alternation, zero-latency memory.
    t0 = cyc;
    bus.d_addr = 28'h0000200;
    bus.i_addr = 28'h0000101;
    bus.d_read = 1'b1;
    bus.i_read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mem_rsp(1, sdat[k]);
      if (k % 2 == 0) begin
        exp_mreq(1'b0, 28'h0000200 + 28'(k), '0, t0 + 4 * k + 1);
        exp_d(sdat[k], t0 + 4 * k + 2);
      end else begin
        exp_mreq(1'b0, 28'h0000100 + 28'(k), '0, t0 + 4 * k + 1);
        exp_i(sdat[k], t0 + 4 * k + 2);
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (k % 2 == 0) bus.d_addr = 28'h0000200 + 28'(k + 2);
      else            bus.i_addr = 28'h0000100 + 28'(k + 2);
      if (k == 7) begin
        bus.d_read = 1'b0;
        bus.i_read = 1'b0;
      end
      tick(3);
    end
    tick(2);
    chk_val("t2_d_rdata_stable", bus.d_rdata, sdat[6]);
    chk_val("t2_i_rdata_stable", bus.i_rdata, sdat[7]);

    // D write-back: rdata must not change.
    t0 = cyc;
    bus.d_addr = 28'h1234567;
    bus.d_wdata = W55;
    bus.d_write = 1'b1;
    mem_rsp(3, JUNK); exp_mreq(1'b1, 28'h1234567, W55, t0 + 1); exp_d(sdat[6], t0 + 4);
    tick(4);
    bus.d_write = 1'b0;
    chk_val("t3_d_rdata_unchanged", bus.d_rdata, sdat[6]);
    tick(3);

    // Request withdrawn in BUSY, then a request held through RESP/GUARD.
    t0 = cyc;
    bus.i_addr = 28'h000003C;
    bus.i_read = 1'b1;
    mem_rsp(2, DW1); exp_mreq(1'b0, 28'h000003C, '0, t0 + 1); exp_i(DW1, t0 + 3);
    tick(1);
    bus.i_read = 1'b0;
    tick(5);
    t1 = cyc;
    bus.i_addr = 28'h000003D;
    bus.i_read = 1'b1;
    mem_rsp(1, DW2); exp_mreq(1'b0, 28'h000003D, '0, t1 + 1); exp_i(DW2, t1 + 2);
    tick(3);
    bus.i_read = 1'b0;
    tick(8);

    // Reset in the second BUSY cycle, then a fresh tie is served D first.
    t0 = cyc;
    bus.i_addr = 28'h0000077;
    bus.i_read = 1'b1;
    mem_rsp(5, JUNK); exp_mreq(1'b0, 28'h0000077, '0, t0 + 1);
    tick(2);
    proc_reset = 1'b1;
    bus.i_read = 1'b0;
    tick(1);
    chk_all_zero("midreset");
    proc_reset = 1'b0;
    tick(1);
    t1 = cyc;
    bus.i_addr = 28'h0000078;
    bus.d_addr = 28'h0000278;
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    mem_rsp(2, RD_D); exp_mreq(1'b0, 28'h0000278, '0, t1 + 1); exp_d(RD_D, t1 + 3);
    mem_rsp(2, RD_I); exp_mreq(1'b0, 28'h0000078, '0, t1 + 6); exp_i(RD_I, t1 + 8);
    tick(1);
    bus.d_read = 1'b0;
    tick(5);
    bus.i_read = 1'b0;
    tick(10);

    chk_int("pending_mem_requests", exp_mem_q.size(), 0);
    chk_int("pending_i_responses",  exp_i_q.size(),   0);
    chk_int("pending_d_responses",  exp_d_q.size(),   0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
